// File: rtl/dmem_responder.sv
// Data-memory slave with a valid/ready request channel, programmable wait states
// and a held valid/ready response channel; one request in flight at a time.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_we;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_be;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               acc_we;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [3:0]         acc_be;
    logic               acc_err;
    logic [IDX_W-1:0]   acc_idx;
    logic [31:0]        acc_word;
    logic [31:0]        acc_rdata;
    logic               do_access;
    logic               mem_we;

    // A zero-wait accept performs the access on the accept edge, so it must use live inputs
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = lat_we;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
        end
        acc_err  = (acc_addr[1:0] != 2'b00) ||
                   (acc_addr[31:2] >= 30'(DEPTH_WORDS)) ||
                   (acc_be == 4'b0000);
        acc_idx  = acc_addr[IDX_W+1:2];
        acc_word = mem[acc_idx];
        for (int i = 0; i < 4; i++) begin
            acc_rdata[8*i +: 8] = acc_be[i] ? acc_word[8*i +: 8] : 8'h00;
        end
        do_access = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == '0));
        mem_we    = do_access && acc_we && !acc_err;
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= acc_err;
                            rsp_rdata <= (acc_we || acc_err) ? 32'h0 : acc_rdata;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (acc_we || acc_err) ? 32'h0 : acc_rdata;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 2;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        e_err;
        logic [31:0] e_rd;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
    logic [31:0] z_rsp_rdata;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
        .rsp_err(z_rsp_err), .busy(z_busy)
    );

    // Push the expected response, then present the request until accepted; returns on the
    // falling edge after the accept edge with the request inputs scrambled.
    task automatic issue(input op_t op, output logic ok);
        exp_t e;
        e.err = op.e_err;
        e.rdata = op.e_rd;
        sb.push_back(e);
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = op.we;
        req_addr = op.addr;
        req_wdata = op.wdata;
        req_be = op.be;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        if (req_ready) begin
            @(posedge clk);
            @(negedge clk);
            ok = 1'b1;
        end
        req_valid = 1'b0;
        req_we = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        req_be = 4'($urandom);
    endtask

    // Wait (bounded) for the response, hold off for 'hold' cycles, then handshake it.
    task automatic collect(input int hold, output logic [31:0] rd, output logic er,
                           output int lat, output logic ok);
        ok = 1'b0;
        rd = '0;
        er = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (rsp_valid) begin
            repeat (hold) @(negedge clk);
            rd = rsp_rdata;
            er = rsp_err;
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
            rsp_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b rd=%h err=%b busy=%b, required 1 0 00000000 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        op_t ops[$];
        logic ok1, ok2, er;
        logic [31:0] rd;
        int lat;
        exp_t e;
        ops.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0});
        ops.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF});
        foreach (ops[k]) begin
            issue(ops[k], ok1);
            if (k == 0) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_in_wait: busy=%b, required 1", busy);
                end
            end
            collect(0, rd, er, lat, ok2);
            e = sb.pop_front();
            n_checks++;
            if (!(ok1 && ok2) || er !== e.err || rd !== e.rdata) begin
                n_fail++;
                $display("FAIL wr_rd[%0d]: ok=%b err=%b rdata=%h, required err=%b rdata=%h",
                         k, ok1 && ok2, er, rd, e.err, e.rdata);
            end
            n_checks++;
            if (lat !== int'(WAITC) + 1) begin
                n_fail++;
                $display("FAIL latency[%0d]: %0d cycles, required %0d", k, lat, WAITC + 1);
            end
        end
    endtask

    task automatic test_partial();
        op_t ops[$];
        logic ok1, ok2, er;
        logic [31:0] rd;
        int lat;
        exp_t e;
        ops.push_back('{1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b0, 32'h0});
        ops.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEAA});
        ops.push_back('{1'b0, 32'h10, 32'h0, 4'h6, 1'b0, 32'h00ADBE00});
        foreach (ops[k]) begin
            issue(ops[k], ok1);
            collect(0, rd, er, lat, ok2);
            e = sb.pop_front();
            n_checks++;
            if (!(ok1 && ok2) || er !== e.err || rd !== e.rdata) begin
                n_fail++;
                $display("FAIL partial[%0d]: ok=%b err=%b rdata=%h, required err=%b rdata=%h",
                         k, ok1 && ok2, er, rd, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_errors();
        op_t ops[$];
        logic ok1, ok2, er;
        logic [31:0] rd;
        int lat;
        exp_t e;
        ops.push_back('{1'b1, 32'h0, 32'h11111111, 4'hF, 1'b0, 32'h0});
        ops.push_back('{1'b0, 32'h13, 32'h0, 4'hF, 1'b1, 32'h0});
        ops.push_back('{1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0});
        ops.push_back('{1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h11111111});
        ops.push_back('{1'b1, 32'h10, 32'h99999999, 4'h0, 1'b1, 32'h0});
        ops.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEAA});
        foreach (ops[k]) begin
            issue(ops[k], ok1);
            collect(1, rd, er, lat, ok2);
            e = sb.pop_front();
            n_checks++;
            if (!(ok1 && ok2) || er !== e.err || rd !== e.rdata) begin
                n_fail++;
                $display("FAIL errors[%0d]: ok=%b err=%b rdata=%h, required err=%b rdata=%h",
                         k, ok1 && ok2, er, rd, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_backpressure();
        op_t op;
        logic ok1, ok2, er;
        logic [31:0] rd;
        int lat;
        exp_t e;
        op = '{1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEAA};
        issue(op, ok1);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEAA || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: vld=%b rdata=%h rdy=%b, required 1 deadbeaa 0",
                         c, rsp_valid, rsp_rdata, req_ready);
            end
            if (c == 0) begin
                req_valid = 1'b1;
                req_we = 1'b1;
                req_addr = 32'h10;
                req_wdata = 32'h55555555;
                req_be = 4'hF;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rd = rsp_rdata;
        er = rsp_err;
        e = sb.pop_front();
        n_checks++;
        if (!ok1 || er !== e.err || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL bp_data: ok=%b err=%b rdata=%h, required err=%b rdata=%h",
                     ok1, er, rd, e.err, e.rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b, required 0 1", rsp_valid, req_ready);
        end
        issue(op, ok1);
        collect(0, rd, er, lat, ok2);
        e = sb.pop_front();
        n_checks++;
        if (!(ok1 && ok2) || er !== e.err || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL bp_no_accept: ok=%b err=%b rdata=%h, required err=%b rdata=%h",
                     ok1 && ok2, er, rd, e.err, e.rdata);
        end
    endtask

    task automatic test_reset_mid();
        op_t op;
        logic ok1, ok2, er;
        logic [31:0] rd;
        int lat;
        exp_t e;
        op = '{1'b1, 32'h20, 32'h0, 4'hF, 1'b0, 32'h0};
        issue(op, ok1);
        collect(0, rd, er, lat, ok2);
        e = sb.pop_front();
        n_checks++;
        if (!(ok1 && ok2) || er !== e.err || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL prewrite_20: ok=%b err=%b rdata=%h, required err=0 rdata=0",
                     ok1 && ok2, er, rd);
        end
        op = '{1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 32'h0};
        issue(op, ok1);
        e = sb.pop_front();
        n_checks++;
        if (!ok1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: ok=%b busy=%b, required 1 1", ok1, busy);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b, required 1 0 0",
                     req_ready, rsp_valid, busy);
        end
        op = '{1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h0};
        issue(op, ok1);
        collect(0, rd, er, lat, ok2);
        e = sb.pop_front();
        n_checks++;
        if (!(ok1 && ok2) || er !== e.err || rd !== e.rdata) begin
            n_fail++;
            $display("FAIL mid_no_commit: ok=%b err=%b rdata=%h, required err=0 rdata=00000000",
                     ok1 && ok2, er, rd);
        end
    endtask

    task automatic test_zero_wait();
        op_t ops[$];
        exp_t e;
        int lat;
        logic accepted;
        ops.push_back('{1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0});
        ops.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D});
        ops.push_back('{1'b0, 32'h10, 32'h0, 4'h9, 1'b0, 32'hCA00000D});
        foreach (ops[k]) begin
            e.err = ops[k].e_err;
            e.rdata = ops[k].e_rd;
            sb.push_back(e);
            @(negedge clk);
            accepted = z_req_ready;
            z_req_valid = 1'b1;
            z_req_we = ops[k].we;
            z_req_addr = ops[k].addr;
            z_req_wdata = ops[k].wdata;
            z_req_be = ops[k].be;
            @(posedge clk);
            @(negedge clk);
            z_req_valid = 1'b0;
            z_req_addr = $urandom;
            z_req_wdata = $urandom;
            lat = 1;
            while (!z_rsp_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            e = sb.pop_front();
            n_checks++;
            if (!accepted || z_rsp_valid !== 1'b1 || z_rsp_err !== e.err ||
                z_rsp_rdata !== e.rdata) begin
                n_fail++;
                $display("FAIL zw_data[%0d]: acc=%b vld=%b err=%b rdata=%h, required err=%b rdata=%h",
                         k, accepted, z_rsp_valid, z_rsp_err, z_rsp_rdata, e.err, e.rdata);
            end
            n_checks++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL zw_latency[%0d]: %0d cycles, required 1", k, lat);
            end
            z_rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            z_rsp_ready = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
        z_rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_partial();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_zero_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
